// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide scheduler:
// op-code constants, default latencies and the arithmetic-op predicate.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_md_scheduler_if.sv
// E-stage <-> mult/div scheduler signal bundle. There is no valid/ready pair:
// in_start is a one-cycle command accepted only while out_busy is low, and out_stall
// is the back-pressure that keeps a dependent D-stage instruction from advancing.
interface e_md_scheduler_if;
  import md_pkg::*;

  logic        in_start;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_D_is_md;
  logic        out_busy;
  logic        out_stall;
  logic [31:0] out_rdata;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  md_state_e   state;

  modport master (
    output in_start, in_op, in_a, in_b, in_D_is_md,
    input  out_busy, out_stall, out_rdata, out_hi, out_lo, state
  );

  modport slave (
    input  in_start, in_op, in_a, in_b, in_D_is_md,
    output out_busy, out_stall, out_rdata, out_hi, out_lo, state
  );

endinterface

// File: rtl/md_arith.sv
// Combinational mult/div datapath: yields {hi, lo} for the latched op and a
// write-enable that is low on divide-by-zero so HI/LO stay untouched.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        we
);

  logic        is_mul;
  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
  assign mul_signed = (op == OP_MULT);

  // The low 64 bits of a product of sign-extended operands are the signed product.
  assign a_ext = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign a_neg   = (op == OP_DIV) && a[31];
  assign b_neg   = (op == OP_DIV) && b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  assign result = is_mul ? prod : {rem, quot};
  assign we     = is_mul || (((op == OP_DIV) || (op == OP_DIVU)) && (b != 32'd0));

endmodule

// File: rtl/e_md_scheduler.sv
// Execute-stage multiply/divide scheduler: owns HI/LO, runs each mult/div for a
// fixed latency and raises the stall that holds a dependent D-stage md instruction.
module e_md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  e_md_scheduler_if.slave     md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e      state_q;
  logic [CNT_W-1:0] count_q;
  logic [2:0]     op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [31:0]    hi_q;
  logic [31:0]    lo_q;

  logic [63:0]    res;
  logic           res_we;
  logic           busy;

  md_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (res),
    .we     (res_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md.in_start) begin
            if (is_md_arith(md.in_op)) begin
              op_q    <= md.in_op;
              a_q     <= md.in_a;
              b_q     <= md.in_b;
              count_q <= ((md.in_op == OP_MULT) || (md.in_op == OP_MULTU))
                         ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_q <= ST_BUSY;
            end else if (md.in_op == OP_MTHI) begin
              hi_q <= md.in_a;
            end else if (md.in_op == OP_MTLO) begin
              lo_q <= md.in_a;
            end
          end
        end
        ST_BUSY: begin
          // Starts arriving here are ignored; the stall keeps them from being legal.
          count_q <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            if (res_we) begin
              {hi_q, lo_q} <= res;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (count_q != '0);
  assign md.out_busy  = busy;
  assign md.out_stall = md.in_D_is_md && (busy || (md.in_start && is_md_arith(md.in_op)));
  assign md.out_rdata = (md.in_op == OP_MFHI) ? hi_q :
                        (md.in_op == OP_MFLO) ? lo_q : 32'd0;
  assign md.out_hi    = hi_q;
  assign md.out_lo    = lo_q;
  assign md.state     = state_q;

endmodule

// File: tb/tb_e_md_scheduler.sv
// Randomized scoreboard bench for e_md_scheduler: a reference model computes HI/LO
// with plain 64-bit arithmetic, and a monitor checks each commit when busy falls.
module tb_e_md_scheduler;
  import md_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  e_md_scheduler_if md();

  e_md_scheduler #(
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          flush = 1'b0;
  bit          prev_busy = 1'b0;
  int          busy_len = 0;
  logic [63:0] exp_v;
  int          exp_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference results from plain signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] model_arith(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: a falling busy marks a commit; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (md.out_busy === 1'b1) begin
      busy_len++;
    end else if (prev_busy) begin
      if (!flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit actual=busy_fall required=none");
        end else begin
          exp_v = exp_q.pop_front();
          exp_l = lat_q.pop_front();
          chk("commit_hilo", {md.out_hi, md.out_lo}, exp_v);
          chk("busy_len", 64'(busy_len), 64'(exp_l));
        end
      end
      busy_len = 0;
    end
    prev_busy = (md.out_busy === 1'b1);
  end

  task automatic wait_idle();
    int n = 0;
    while (md.out_busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle_within_40");
    end
  endtask

  // Issue one command in the first idle cycle; returns at the next negedge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd);
    logic [63:0] e;
    wait_idle();
    md.in_start   = 1'b1;
    md.in_op      = op;
    md.in_a       = a;
    md.in_b       = b;
    md.in_D_is_md = dmd;
    if (is_md_arith(op)) begin
      e = model_arith(op, a, b, {m_hi, m_lo});
      {m_hi, m_lo} = e;
      exp_q.push_back(e);
      lat_q.push_back(((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LAT : DIV_LAT);
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
    #1;
    chk("stall_start", 64'(md.out_stall), 64'(dmd && is_md_arith(op)));
    @(negedge clk);
    md.in_start = 1'b0;
    if (op == OP_MTHI || op == OP_MTLO) begin
      chk("mt_hilo", {md.out_hi, md.out_lo}, {m_hi, m_lo});
      chk("mt_busy", 64'(md.out_busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    md.in_start   = 1'b0;
    md.in_op      = OP_MFLO;
    md.in_a       = 32'd0;
    md.in_b       = 32'd0;
    md.in_D_is_md = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset_busy", 64'(md.out_busy), 64'd0);
    chk("reset_stall", 64'(md.out_stall), 64'd0);
    chk("reset_hilo", {md.out_hi, md.out_lo}, 64'd0);
    chk("reset_rdata", 64'(md.out_rdata), 64'd0);

    start_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    chk("mult_neg", {md.out_hi, md.out_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    start_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    chk("multu", {md.out_hi, md.out_lo}, 64'h0000_0002_FFFF_FFFA);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    chk("div_neg", {md.out_hi, md.out_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    start_op(OP_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle();
    chk("divu_zero", {md.out_hi, md.out_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    chk("div_ovf", {md.out_hi, md.out_lo}, 64'h0000_0000_8000_0000);

    // Back-to-back MFLO in D: held through the start cycle and all busy cycles.
    start_op(OP_MULT, 32'd1234, 32'hFFFF_FF00, 1'b1);
    md.in_op = OP_MFLO;
    for (int i = 0; i < MULT_LAT; i++) begin
      #1;
      chk("stall_busy", 64'(md.out_stall), 64'd1);
      @(negedge clk);
    end
    chk("stall_release", 64'(md.out_stall), 64'd0);
    chk("rdata_lo", 64'(md.out_rdata), 64'(m_lo));
    md.in_D_is_md = 1'b0;

    start_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    start_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
    md.in_op = OP_MFHI;
    #1;
    chk("rdata_hi", 64'(md.out_rdata), 64'h1234_5678);
    md.in_op = OP_MTHI;
    #1;
    chk("rdata_other", 64'(md.out_rdata), 64'd0);

    // A start during busy cycle 2 must be ignored.
    start_op(OP_MULT, 32'd300, 32'd7, 1'b0);
    @(negedge clk);
    md.in_start = 1'b1;
    md.in_op    = OP_DIVU;
    md.in_a     = 32'd100;
    md.in_b     = 32'd7;
    @(negedge clk);
    md.in_start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("ignored_busy", 64'(md.out_busy), 64'd0);
    chk("ignored_hilo", {md.out_hi, md.out_lo}, {m_hi, m_lo});

    // Reset during busy cycle 4 discards the pending divide.
    start_op(OP_DIV, 32'd1000, 32'd3, 1'b1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    lat_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(md.out_busy), 64'd0);
    chk("rst_stall", 64'(md.out_stall), 64'd0);
    chk("rst_hilo", {md.out_hi, md.out_lo}, 64'd0);
    reset = 1'b0;
    md.in_D_is_md = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    chk("rst_no_late_write", {md.out_hi, md.out_lo}, 64'd0);
    flush = 1'b0;

    for (int i = 0; i < 30; i++) begin
      start_op(3'($urandom_range(0, 5)), pick(), pick(), 1'($urandom_range(0, 1)));
      md.in_D_is_md = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("final_hilo", {md.out_hi, md.out_lo}, {m_hi, m_lo});
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
